posit_acc_encode: RTL

//  Downstream stage of the accumulator scale-factor extractor: turns its sign/sf/mantissa/flag outputs into a

---
 rtl/posit_acc_encode.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/posit_acc_encode.sv
// Posit encoder for the accumulator path: sign/sf/mantissa/flags -> WIDTH-bit posit, RNE, saturating.
// Optional macro POSIT_ENC_STATS_EN adds saturating counters for delivered maxpos/minpos/zero results.
module posit_acc_encode #(
  parameter int WIDTH = 8,
  parameter int EXP   = 2,
  parameter int MTS   = WIDTH - 3 - EXP,
  parameter int REGI  = $clog2(WIDTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rstn,
  input  logic                      clr_i,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic                      sign_i,
  input  logic                      ovf_i,
  input  logic                      udf_i,
  input  logic                      nzero_i,
  input  logic signed [REGI+EXP:0]  sf_i,
  input  logic [2*MTS+1:0]          mts_i,
  output logic                      out_vld,
  input  logic                      out_rdy,
`ifdef POSIT_ENC_STATS_EN
  output logic [15:0]               stat_ovf_cnt,
  output logic [15:0]               stat_udf_cnt,
  output logic [15:0]               stat_zero_cnt,
`endif
  output logic [WIDTH-1:0]          out_data
);

  localparam int SFW = REGI + EXP + 1;
  localparam int TW  = EXP + 2*MTS + 1;
  localparam int LW  = WIDTH + TW;
  localparam int KW  = WIDTH - 1;
  localparam logic signed [SFW-1:0] K_MAX = SFW'(WIDTH - 2);
  localparam logic signed [SFW-1:0] K_MIN = -K_MAX;

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_MAX, CLS_MIN} cls_t;

  function automatic logic [WIDTH-1:0] round_mag(input logic [KW-1:0] kept,
                                                 input logic g, input logic s);
    logic [KW-1:0] r;
    r = kept;
    // an all-ones body is already maxpos; rounding must not carry into the sign bit
    if (g && (s || kept[0]) && !(&kept)) r = kept + 1'b1;
    return {1'b0, r};
  endfunction

  function automatic logic [WIDTH-1:0] sat_encode(input cls_t cls, input logic sgn,
                                                  input logic [KW-1:0] kept,
                                                  input logic g, input logic s);
    logic [WIDTH-1:0] m;
    case (cls)
      CLS_ZERO: m = '0;
      CLS_MAX:  m = {1'b0, {KW{1'b1}}};
      CLS_MIN:  m = WIDTH'(1);
      default:  m = round_mag(kept, g, s);
    endcase
    return (sgn && cls != CLS_ZERO) ? (~m + 1'b1) : m;
  endfunction

  logic vld_p1, vld_p2, adv_p2;
  logic [WIDTH-1:0] data_p2;

  assign adv_p2   = ~vld_p2 | out_rdy;
  assign in_rdy   = ~vld_p1 | adv_p2;
  assign out_vld  = vld_p2;
  assign out_data = data_p2;

  // ---- p0: regime by arithmetic shift of a 2-bit seed, then classify
  logic signed [SFW-1:0] k_p0;
  logic [SFW-1:0]        sh_p0;
  logic signed [LW-1:0]  pat_p0, body_p0;
  cls_t                  cls_p0;
  logic                  unused_hidden;

  assign unused_hidden = mts_i[2*MTS+1];
  assign k_p0    = sf_i >>> EXP;
  assign sh_p0   = k_p0[SFW-1] ? ~k_p0 : k_p0;
  assign pat_p0  = {~k_p0[SFW-1], k_p0[SFW-1], sf_i[EXP-1:0], mts_i[2*MTS:0], {(WIDTH-2){1'b0}}};
  assign body_p0 = pat_p0 >>> sh_p0;

  always_comb begin
    cls_p0 = CLS_NORM;
    if (!nzero_i)                  cls_p0 = CLS_ZERO;
    else if (ovf_i)                cls_p0 = CLS_MAX;
    else if (udf_i)                cls_p0 = CLS_MIN;
    else if (k_p0 >= K_MAX)        cls_p0 = CLS_MAX;
    else if (k_p0 < K_MIN)         cls_p0 = CLS_MIN;
  end

  // ---- p1: kept body bits, guard, sticky
  logic [KW-1:0] kept_p1;
  logic          guard_p1, sticky_p1, sign_p1;
  cls_t          cls_p1;

  always_ff @(posedge clk_i) begin
    if (in_vld && in_rdy) begin
      kept_p1   <= body_p0[LW-1 -: KW];
      guard_p1  <= body_p0[TW];
      sticky_p1 <= |body_p0[TW-1:0];
      sign_p1   <= sign_i;
      cls_p1    <= cls_p0;
    end
  end

  // ---- p2: round, saturate, negate into the output register
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else if (clr_i) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      if (in_rdy) vld_p1 <= in_vld;
      if (adv_p2) begin
        vld_p2 <= vld_p1;
        if (vld_p1) data_p2 <= sat_encode(cls_p1, sign_p1, kept_p1, guard_p1, sticky_p1);
      end
    end
  end

`ifdef POSIT_ENC_STATS_EN
  cls_t cls_p2;
  logic deliver;

  assign deliver = vld_p2 & out_rdy;

  always_ff @(posedge clk_i) begin
    if (adv_p2 && vld_p1) cls_p2 <= cls_p1;
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      stat_ovf_cnt  <= '0;
      stat_udf_cnt  <= '0;
      stat_zero_cnt <= '0;
    end else if (clr_i) begin
      stat_ovf_cnt  <= '0;
      stat_udf_cnt  <= '0;
      stat_zero_cnt <= '0;
    end else if (deliver) begin
      if (cls_p2 == CLS_MAX  && stat_ovf_cnt  != 16'hFFFF) stat_ovf_cnt  <= stat_ovf_cnt + 16'd1;
      if (cls_p2 == CLS_MIN  && stat_udf_cnt  != 16'hFFFF) stat_udf_cnt  <= stat_udf_cnt + 16'd1;
      if (cls_p2 == CLS_ZERO && stat_zero_cnt != 16'hFFFF) stat_zero_cnt <= stat_zero_cnt + 16'd1;
    end
  end
`endif

endmodule
